// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a shared single-port RAM: round-robin when idle,
// exclusive ownership while a requester holds its lock, one-cycle read responses.

module ram_arbiter_rsp #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fire,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);
  logic                  pend;
  logic [DATA_WIDTH-1:0] hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0;
      hold <= '0;
    end else begin
      pend <= fire;
      if (pend) hold <= ram_data_out;
    end
  end

  // RAM data arrives in the pulse cycle; pass it through, then keep it in hold.
  // Gating with rst_n kills a response whose read was accepted just before reset.
  assign rsp_valid = pend & rst_n;
  assign rsp_rdata = rsp_valid ? ram_data_out : hold;
endmodule

module ram_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_0,
  output logic                  req_ready_0,
  input  logic                  req_we_0,
  input  logic                  req_lock_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  output logic                  rsp_valid_0,
  output logic [DATA_WIDTH-1:0] rsp_rdata_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic                  req_we_1,
  input  logic                  req_lock_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  rsp_valid_1,
  output logic [DATA_WIDTH-1:0] rsp_rdata_1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t                                 state;
  logic                                   last;
  logic [NUM_REQ-1:0]                     valid, we, lock, acc, fire, rvld;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     wdata, rdata;
  logic                                   sel;

  assign valid = {req_valid_1, req_valid_0};
  assign we    = {req_we_1,    req_we_0};
  assign lock  = {req_lock_1,  req_lock_0};
  assign addr  = {req_addr_1,  req_addr_0};
  assign wdata = {req_wdata_1, req_wdata_0};

  // Grant only goes to a valid requester, so a grant is also an accept.
  always_comb begin
    acc = '0;
    case (state)
      IDLE:    acc = (valid == 2'b11) ? (last ? 2'b01 : 2'b10) : valid;
      OWN0:    acc[0] = valid[0];
      OWN1:    acc[1] = valid[1];
      default: acc = '0;
    endcase
    if (!rst_n) acc = '0;
  end

  assign sel         = acc[1];
  assign req_ready_0 = acc[0];
  assign req_ready_1 = acc[1];
  assign fire        = acc & ~we;

  always_comb begin
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    if (|acc) begin
      ram_we      = we[sel];
      ram_addr    = addr[sel];
      ram_data_in = wdata[sel];
    end
  end

  // last = most recently granted requester; reset value 1 favours requester 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else if (|acc) begin
      if (lock[sel]) begin
        state <= sel ? OWN1 : OWN0;
      end else begin
        state <= IDLE;
        last  <= sel;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    ram_arbiter_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp (
      .clk          (clk),
      .rst_n        (rst_n),
      .fire         (fire[i]),
      .ram_data_out (ram_data_out),
      .rsp_valid    (rvld[i]),
      .rsp_rdata    (rdata[i])
    );
  end

  assign rsp_valid_0 = rvld[0];
  assign rsp_valid_1 = rvld[1];
  assign rsp_rdata_0 = rdata[0];
  assign rsp_rdata_1 = rdata[1];
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM (1-cycle read latency).

module tb_ram_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid_0, req_we_0, req_lock_0;
  logic       req_valid_1, req_we_1, req_lock_1;
  logic [3:0] req_addr_0, req_addr_1;
  logic [7:0] req_wdata_0, req_wdata_1;
  logic       req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [7:0] rsp_rdata_0, rsp_rdata_1;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_data_in, ram_data_out;
  logic [7:0] mem [16];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
    .req_lock_0(req_lock_0), .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
    .req_lock_1(req_lock_1), .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  // Read-before-write RAM; a write at T is visible to a read presented at T+1.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
    ram_data_out = 8'h00;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int n, input logic v, input logic w, input logic lk,
                     input logic [3:0] a, input logic [7:0] d);
    if (n == 0) begin
      req_valid_0 = v; req_we_0 = w; req_lock_0 = lk; req_addr_0 = a; req_wdata_0 = d;
    end else begin
      req_valid_1 = v; req_we_1 = w; req_lock_1 = lk; req_addr_1 = a; req_wdata_1 = d;
    end
  endtask

  initial begin
    logic g0;
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 4'd0, 8'h00);
    drv(1, 0, 0, 0, 4'd0, 8'h00);
    tick(); tick();
    // Reset: requester 0 tries a write that must be blocked
    drv(0, 1, 1, 0, 4'd5, 8'hFF);
    #3;
    chk("rst_ready0", req_ready_0, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_rsp_valid0", rsp_valid_0, 0);
    chk("rst_rdata0", rsp_rdata_0, 8'h00);
    chk("rst_rdata1", rsp_rdata_1, 8'h00);

    // Single write then read
    tick(); rst_n = 1'b1;
    drv(0, 1, 1, 0, 4'd3, 8'hA5);
    #3;
    chk("wr_ready0", req_ready_0, 1);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 3);
    chk("wr_ram_data_in", ram_data_in, 8'hA5);
    tick(); drv(0, 1, 0, 0, 4'd3, 8'h00);
    #3;
    chk("rd_ready0", req_ready_0, 1);
    chk("rd_ram_we", ram_we, 0);
    chk("wr_no_rsp", rsp_valid_0, 0);
    tick(); drv(0, 0, 0, 0, 4'd0, 8'h00);
    #3;
    chk("rd_rsp_valid0", rsp_valid_0, 1);
    chk("rd_rdata0", rsp_rdata_0, 8'hA5);
    chk("rd_rsp_valid1", rsp_valid_1, 0);
    chk("idle_ram_addr", ram_addr, 0);
    tick(); #3;
    chk("rsp_pulse_end", rsp_valid_0, 0);
    chk("rdata0_hold", rsp_rdata_0, 8'hA5);

    // Contention after a fresh reset: grants 0,1,0,1,0
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    drv(0, 1, 0, 0, 4'd1, 8'h00);
    drv(1, 1, 0, 0, 4'd2, 8'h00);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      #3;
      g0 = (k % 2 == 0);
      chk($sformatf("rr_ready0_%0d", k), req_ready_0, g0);
      chk($sformatf("rr_ready1_%0d", k), req_ready_1, !g0);
      chk($sformatf("rr_addr_%0d", k), ram_addr, g0 ? 4'd1 : 4'd2);
      if (k > 0) begin
        chk($sformatf("rr_rsp0_%0d", k), rsp_valid_0, !g0);
        chk($sformatf("rr_rsp1_%0d", k), rsp_valid_1, g0);
        if (g0) chk($sformatf("rr_rdata1_%0d", k), rsp_rdata_1, 8'h42);
        else    chk($sformatf("rr_rdata0_%0d", k), rsp_rdata_0, 8'h41);
      end
    end

    // Lock: requester 1 does 3 locked accesses then one unlocked
    tick(); drv(1, 1, 1, 1, 4'd7, 8'h77);
    #3;
    chk("lk0_ready0", req_ready_0, 0);
    chk("lk0_ready1", req_ready_1, 1);
    chk("lk0_ram_we", ram_we, 1);
    chk("lk0_rsp0", rsp_valid_0, 1);
    tick(); drv(1, 1, 0, 1, 4'd7, 8'h00);
    #3;
    chk("lk1_ready0", req_ready_0, 0);
    chk("lk1_ready1", req_ready_1, 1);
    chk("lk1_no_rsp1", rsp_valid_1, 0);
    tick(); #3;
    chk("lk2_ready0", req_ready_0, 0);
    chk("lk2_rsp1", rsp_valid_1, 1);
    chk("lk2_rdata1", rsp_rdata_1, 8'h77);
    tick(); drv(1, 1, 0, 0, 4'd2, 8'h00);
    #3;
    chk("lk3_ready0", req_ready_0, 0);
    chk("lk3_ready1", req_ready_1, 1);
    chk("lk3_rdata1", rsp_rdata_1, 8'h77);
    // Release: requester 0 wins next, and takes its own lock
    tick(); drv(0, 1, 0, 1, 4'd1, 8'h00);
    #3;
    chk("rel_ready0", req_ready_0, 1);
    chk("rel_ready1", req_ready_1, 0);
    chk("rel_rdata1", rsp_rdata_1, 8'h42);

    // Lock hold: requester 0 idles for 5 cycles, requester 1 must stay blocked
    for (int k = 0; k < 5; k++) begin
      tick();
      drv(0, 0, 0, 0, 4'd0, 8'h00);
      #3;
      chk($sformatf("hold_ready1_%0d", k), req_ready_1, 0);
      chk($sformatf("hold_ram_we_%0d", k), ram_we, 0);
      if (k == 0) chk("hold_rsp0", rsp_valid_0, 1);
    end

    // Write/read adjacency across requesters, unlocking requester 0
    tick(); drv(0, 1, 1, 0, 4'd15, 8'h3C);
    #3;
    chk("adj_ready0", req_ready_0, 1);
    chk("adj_ready1", req_ready_1, 0);
    chk("adj_ram_addr", ram_addr, 15);
    tick();
    drv(0, 0, 0, 0, 4'd0, 8'h00);
    drv(1, 1, 0, 0, 4'd15, 8'h00);
    #3;
    chk("adj_rd_ready1", req_ready_1, 1);
    chk("adj_no_rsp0", rsp_valid_0, 0);
    tick(); drv(1, 1, 0, 0, 4'd2, 8'h00);
    #3;
    chk("adj_rsp1", rsp_valid_1, 1);
    chk("adj_rdata1", rsp_rdata_1, 8'h3C);
    chk("mr_ready1", req_ready_1, 1);

    // Reset right after an accepted read
    tick(); rst_n = 1'b0;
    drv(0, 1, 1, 0, 4'd9, 8'h99);
    #3;
    chk("mr_no_rsp1", rsp_valid_1, 0);
    chk("mr_ready0", req_ready_0, 0);
    chk("mr_ready1_rst", req_ready_1, 0);
    chk("mr_ram_we", ram_we, 0);
    tick(); #3;
    chk("mr_rdata1_clr", rsp_rdata_1, 8'h00);
    chk("mr_rsp1_rst", rsp_valid_1, 0);
    chk("mr_ram_we2", ram_we, 0);
    tick(); rst_n = 1'b1;
    drv(0, 1, 0, 0, 4'd1, 8'h00);
    #3;
    chk("post_ready0", req_ready_0, 1);
    chk("post_ready1", req_ready_1, 0);
    tick(); #3;
    chk("post_rsp0", rsp_valid_0, 1);
    chk("post_rdata0", rsp_rdata_0, 8'h41);
    chk("no_write_in_rst", mem[9], 8'h49);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
